// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions four raw slide switches for the PWM generator. Each bit is
//   synchronised through two flops and then debounced on its own. The
//   debounced vector is clamped to MAX_CODE before it drives the PWM
//   duty input.
//
//   Parameters
//     DEBOUNCE_CYCLES : cycles a synchronised bit must differ from its stable
//                       value before the stable value follows it (>= 2)
//     CNT_W           : debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//     MAX_CODE        : highest duty code passed downstream
//
//   Ports
//     clk          : system clock, rising edge
//     rst          : asynchronous active-high reset
//     switch_raw   : asynchronous switch pins
//     sw_stable    : debounced switch vector
//     duty_code    : min(sw_stable, MAX_CODE)
//     change_pulse : one-cycle strobe when sw_stable changes
//     clamped      : high while sw_stable > MAX_CODE

// One lane: synchroniser plus debounce counter for a single switch bit.
module switch_debouncer_bit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_upd     // stable value flips on the coming edge
);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff   = r_sync1 ^ r_stable;
  assign o_upd    = w_diff & (r_cnt == LP_LAST);
  assign o_stable = r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      // Any return to the stable value clears the count, so partial
      // counts never accumulate across bounces.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_stable <= r_sync1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int MAX_CODE        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] switch_raw,
  output logic [3:0] sw_stable,
  output logic [3:0] duty_code,
  output logic       change_pulse,
  output logic       clamped
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] LP_MAX    = 4'(MAX_CODE);

  logic [NUM_LANES-1:0] w_stable;
  logic [NUM_LANES-1:0] w_upd;
  logic                 r_change;
  logic                 w_over;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    switch_debouncer_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (switch_raw[g]),
      .o_stable (w_stable[g]),
      .o_upd    (w_upd[g])
    );
  end

  // Registered from the lanes' update flags, so the strobe lines up with the
  // cycle in which sw_stable first shows the new value. Several lanes
  // updating on the same edge give a single strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_change <= 1'b0;
    else     r_change <= |w_upd;
  end

  assign w_over       = (w_stable > LP_MAX);
  assign sw_stable    = w_stable;
  assign duty_code    = w_over ? LP_MAX : w_stable;
  assign clamped      = w_over;
  assign change_pulse = r_change;
endmodule
